// File: rtl/regfile_rename.sv
// Architectural register file with rename tags; reads are zero-latency (commit bypass included), updates on clk.
// No backpressure: rdy=0 freezes all state while reads stay live; clear drops every tag on the next edge.
module regfile_rename #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic [5:0]       rs1_to_reg,
  input  logic [5:0]       rs2_to_reg,
  input  logic [5:0]       rd_to_reg,
  input  logic             issue_valid,
  input  logic [ROB_W-1:0] issue_entry,
  output logic [31:0]      Vj_from_reg,
  output logic [31:0]      Vk_from_reg,
  output logic [ROB_W-1:0] Qj_from_reg,
  output logic [ROB_W-1:0] Qk_from_reg,
  input  logic             commit_valid,
  input  logic [5:0]       commit_rd,
  input  logic [ROB_W-1:0] commit_entry,
  input  logic [31:0]      commit_value
);

  logic [31:0]      value_q [32];
  logic [31:0]      value_d [32];
  logic [ROB_W-1:0] tag_q   [32];
  logic [ROB_W-1:0] tag_d   [32];

  logic [5:0]       src_idx [2];
  logic [31:0]      src_val [2];
  logic [ROB_W-1:0] src_tag [2];

  logic commit_ok;
  logic issue_ok;

  // Indices 32..63 and x0 never address storage.
  assign commit_ok = commit_valid && !commit_rd[5] && (commit_rd[4:0] != 5'd0);
  assign issue_ok  = issue_valid && !rd_to_reg[5] && (rd_to_reg[4:0] != 5'd0);

  assign src_idx[0] = rs1_to_reg;
  assign src_idx[1] = rs2_to_reg;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      src_val[p] = '0;
      src_tag[p] = '0;
      if (!src_idx[p][5] && (src_idx[p][4:0] != 5'd0)) begin
        src_val[p] = value_q[src_idx[p][4:0]];
        src_tag[p] = tag_q[src_idx[p][4:0]];
        // The producer is retiring right now: forward its result and drop the dependency.
        if (commit_valid && (commit_rd == src_idx[p]) && (src_tag[p] != '0) &&
            (src_tag[p] == commit_entry)) begin
          src_val[p] = commit_value;
          src_tag[p] = '0;
        end
      end
    end
  end

  assign Vj_from_reg = src_val[0];
  assign Qj_from_reg = src_tag[0];
  assign Vk_from_reg = src_val[1];
  assign Qk_from_reg = src_tag[1];

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    if (rdy) begin
      if (commit_ok) begin
        value_d[commit_rd[4:0]] = commit_value;
        // A younger producer may already own this register; only the matching entry releases it.
        if (tag_q[commit_rd[4:0]] == commit_entry) begin
          tag_d[commit_rd[4:0]] = '0;
        end
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) begin
          tag_d[i] = '0;
        end
      end else if (issue_ok) begin
        tag_d[rd_to_reg[4:0]] = issue_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Bench for regfile_rename: directed vector table, reset corner cases, then random traffic against a reference model.
module tb_regfile_rename;

  localparam int ROB_W = 4;

  logic             clk;
  logic             rst;
  logic             rdy;
  logic             clear;
  logic [5:0]       rs1_to_reg;
  logic [5:0]       rs2_to_reg;
  logic [5:0]       rd_to_reg;
  logic             issue_valid;
  logic [ROB_W-1:0] issue_entry;
  logic [31:0]      Vj_from_reg;
  logic [31:0]      Vk_from_reg;
  logic [ROB_W-1:0] Qj_from_reg;
  logic [ROB_W-1:0] Qk_from_reg;
  logic             commit_valid;
  logic [5:0]       commit_rd;
  logic [ROB_W-1:0] commit_entry;
  logic [31:0]      commit_value;

  regfile_rename #(.ROB_W(ROB_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .clear        (clear),
    .rs1_to_reg   (rs1_to_reg),
    .rs2_to_reg   (rs2_to_reg),
    .rd_to_reg    (rd_to_reg),
    .issue_valid  (issue_valid),
    .issue_entry  (issue_entry),
    .Vj_from_reg  (Vj_from_reg),
    .Vk_from_reg  (Vk_from_reg),
    .Qj_from_reg  (Qj_from_reg),
    .Qk_from_reg  (Qk_from_reg),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_entry (commit_entry),
    .commit_value (commit_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             rdy_i, clr_i, iv_i;
    logic [5:0]       rd_i;
    logic [ROB_W-1:0] ie_i;
    logic [5:0]       rs1_i, rs2_i;
    logic             cv_i;
    logic [5:0]       crd_i;
    logic [ROB_W-1:0] ce_i;
    logic [31:0]      cval_i;
    logic [31:0]      evj;
    logic [ROB_W-1:0] eqj;
    logic [31:0]      evk;
    logic [ROB_W-1:0] eqk;
  } vec_t;

  vec_t vecs[22];

  // Reference state: one value and one pending-producer tag per architectural register.
  logic [31:0]      m_val [32];
  logic [ROB_W-1:0] m_tag [32];

  function automatic vec_t mk(logic r, logic c, logic iv, logic [5:0] rd, logic [ROB_W-1:0] ie,
                              logic [5:0] s1, logic [5:0] s2, logic cv, logic [5:0] crd,
                              logic [ROB_W-1:0] ce, logic [31:0] cval, logic [31:0] vj,
                              logic [ROB_W-1:0] qj, logic [31:0] vk, logic [ROB_W-1:0] qk);
    vec_t v;
    v.rdy_i = r;  v.clr_i = c;  v.iv_i = iv;  v.rd_i = rd;  v.ie_i = ie;
    v.rs1_i = s1; v.rs2_i = s2; v.cv_i = cv;  v.crd_i = crd; v.ce_i = ce; v.cval_i = cval;
    v.evj = vj;   v.eqj = qj;   v.evk = vk;   v.eqk = qk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rdy = v.rdy_i;  clear = v.clr_i;  issue_valid = v.iv_i;  rd_to_reg = v.rd_i;
    issue_entry = v.ie_i;  rs1_to_reg = v.rs1_i;  rs2_to_reg = v.rs2_i;
    commit_valid = v.cv_i;  commit_rd = v.crd_i;  commit_entry = v.ce_i;  commit_value = v.cval_i;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endtask

  function automatic bit is_arch(input logic [5:0] idx);
    return (idx < 6'd32) && (idx != 6'd0);
  endfunction

  task automatic model_read(input logic [5:0] idx, output logic [31:0] v, output logic [ROB_W-1:0] q);
    v = '0;
    q = '0;
    if (is_arch(idx)) begin
      if (m_tag[idx] != 0 && commit_valid && commit_rd == idx && m_tag[idx] == commit_entry) begin
        v = commit_value;
      end else begin
        v = m_val[idx];
        q = m_tag[idx];
      end
    end
  endtask

  task automatic model_edge();
    if (rdy) begin
      if (commit_valid && is_arch(commit_rd)) begin
        m_val[commit_rd] = commit_value;
        if (m_tag[commit_rd] == commit_entry) m_tag[commit_rd] = '0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) m_tag[i] = '0;
      end else if (issue_valid && is_arch(rd_to_reg)) begin
        m_tag[rd_to_reg] = issue_entry;
      end
    end
  endtask

  // One clock against the model: compare on the falling edge, advance the model, return just after the rising edge.
  task automatic model_cycle(input string tagname);
    logic [31:0]      vj, vk;
    logic [ROB_W-1:0] qj, qk;
    @(negedge clk);
    model_read(rs1_to_reg, vj, qj);
    model_read(rs2_to_reg, vk, qk);
    chk({tagname, " Vj"}, Vj_from_reg, vj);
    chk({tagname, " Qj"}, 32'(Qj_from_reg), 32'(qj));
    chk({tagname, " Vk"}, Vk_from_reg, vk);
    chk({tagname, " Qk"}, 32'(Qk_from_reg), 32'(qk));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_idx();
    if ($urandom_range(0, 7) == 0) return 6'($urandom_range(32, 63));
    return 6'($urandom_range(0, 12));
  endfunction

  initial begin
    rst = 1'b0;  rdy = 1'b0;  clear = 1'b0;
    rs1_to_reg = '0;  rs2_to_reg = '0;  rd_to_reg = '0;
    issue_valid = 1'b0;  issue_entry = '0;
    commit_valid = 1'b0;  commit_rd = '0;  commit_entry = '0;  commit_value = '0;

    //            rdy clr iv rd  ie  rs1 rs2 cv crd ce  cval          Vj            Qj  Vk            Qk
    vecs[0]  = mk(1, 0, 1, 5,  3, 5,  40, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        0);
    vecs[1]  = mk(1, 0, 0, 0,  0, 5,  40, 0, 0,  0, 32'h0,        32'h0,        3, 32'h0,        0);
    vecs[2]  = mk(1, 0, 0, 0,  0, 5,  40, 1, 5,  3, 32'hDEAD,     32'hDEAD,     0, 32'h0,        0);
    vecs[3]  = mk(1, 0, 0, 0,  0, 5,  40, 0, 0,  0, 32'h0,        32'hDEAD,     0, 32'h0,        0);
    vecs[4]  = mk(1, 0, 1, 1,  5, 1,  40, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        0);
    vecs[5]  = mk(1, 0, 0, 0,  0, 1,  40, 0, 0,  0, 32'h0,        32'h0,        5, 32'h0,        0);
    vecs[6]  = mk(1, 0, 1, 7,  2, 40, 40, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        0);
    vecs[7]  = mk(1, 0, 1, 7,  4, 40, 7,  0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        2);
    vecs[8]  = mk(1, 0, 0, 0,  0, 40, 7,  1, 7,  2, 32'h11,       32'h0,        0, 32'h0,        4);
    vecs[9]  = mk(1, 0, 0, 0,  0, 40, 7,  0, 0,  0, 32'h0,        32'h0,        0, 32'h11,       4);
    vecs[10] = mk(1, 0, 1, 9,  1, 40, 40, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        0);
    vecs[11] = mk(1, 0, 1, 9,  6, 9,  40, 1, 9,  1, 32'h99,       32'h99,       0, 32'h0,        0);
    vecs[12] = mk(1, 0, 0, 0,  0, 9,  40, 0, 0,  0, 32'h0,        32'h99,       6, 32'h0,        0);
    vecs[13] = mk(1, 0, 1, 0,  7, 0,  9,  1, 0,  7, 32'h55,       32'h0,        0, 32'h99,       6);
    vecs[14] = mk(1, 0, 1, 40, 7, 8,  0,  0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        0);
    vecs[15] = mk(1, 0, 0, 0,  0, 8,  0,  0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        0);
    vecs[16] = mk(1, 0, 1, 3,  2, 40, 40, 0, 0,  0, 32'h0,        32'h0,        0, 32'h0,        0);
    vecs[17] = mk(1, 0, 1, 4,  5, 3,  40, 0, 0,  0, 32'h0,        32'h0,        2, 32'h0,        0);
    vecs[18] = mk(1, 1, 1, 6,  7, 3,  4,  1, 10, 3, 32'hAB,       32'h0,        2, 32'h0,        5);
    vecs[19] = mk(1, 0, 0, 0,  0, 6,  10, 0, 0,  0, 32'h0,        32'h0,        0, 32'hAB,       0);
    vecs[20] = mk(0, 0, 1, 4,  1, 4,  3,  1, 4,  5, 32'h44,       32'h0,        0, 32'h0,        0);
    vecs[21] = mk(1, 0, 0, 0,  0, 4,  5,  0, 0,  0, 32'h0,        32'h0,        0, 32'hDEAD,     0);

    #2;
    rs1_to_reg = 6'd5;
    rs2_to_reg = 6'd31;
    #1;
    chk("reset Vj", Vj_from_reg, 32'h0);
    chk("reset Qj", 32'(Qj_from_reg), 32'h0);
    chk("reset Vk", Vk_from_reg, 32'h0);
    chk("reset Qk", 32'(Qk_from_reg), 32'h0);
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d Vj", i), Vj_from_reg, vecs[i].evj);
      chk($sformatf("vec%0d Qj", i), 32'(Qj_from_reg), 32'(vecs[i].eqj));
      chk($sformatf("vec%0d Vk", i), Vk_from_reg, vecs[i].evk);
      chk($sformatf("vec%0d Qk", i), 32'(Qk_from_reg), 32'(vecs[i].eqk));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-cycle while a rename is pending on x5 (which holds 0xDEAD).
    apply(mk(1, 0, 1, 5, 4, 5, 10, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0));
    #1;
    chk("pre-arst Vj", Vj_from_reg, 32'hDEAD);
    chk("pre-arst Vk", Vk_from_reg, 32'hAB);
    #1;
    rst = 1'b0;
    #1;
    chk("arst Vj", Vj_from_reg, 32'h0);
    chk("arst Vk", Vk_from_reg, 32'h0);
    issue_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("post-arst Qj", 32'(Qj_from_reg), 32'h0);
    chk("post-arst Vj", Vj_from_reg, 32'h0);
    model_reset();

    // First edge after reset release must already take an issue.
    rd_to_reg = 6'd2;  issue_entry = 4'd9;  issue_valid = 1'b1;  rs1_to_reg = 6'd2;  rs2_to_reg = 6'd40;
    model_cycle("first-edge");
    issue_valid = 1'b0;
    @(negedge clk);
    chk("first-edge Qj", 32'(Qj_from_reg), 32'd9);
    @(posedge clk);
    #1;

    for (int n = 0; n < 600; n++) begin
      rdy          = ($urandom_range(0, 9) != 0);
      clear        = ($urandom_range(0, 19) == 0);
      issue_valid  = ($urandom_range(0, 2) != 0);
      rd_to_reg    = rand_idx();
      issue_entry  = ROB_W'($urandom_range(1, 15));
      rs1_to_reg   = rand_idx();
      rs2_to_reg   = rand_idx();
      commit_valid = ($urandom_range(0, 1) != 0);
      commit_rd    = ($urandom_range(0, 1) != 0) ? rs1_to_reg : rand_idx();
      commit_entry = ROB_W'($urandom_range(1, 15));
      if ($urandom_range(0, 1) != 0 && is_arch(commit_rd) && m_tag[commit_rd] != 0)
        commit_entry = m_tag[commit_rd];
      commit_value = $urandom;
      model_cycle($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_rename.md
REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 SHALL have parameter ROB_W, default 4, the ROB tag width; tag value 0 is reserved to mean "no dependency", and the ROB allocates entries 1..2^ROB_W-1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rdy, input, 1 bit: global ready; low freezes all state.
REQ-005 SHALL have port clear, input, 1 bit: misprediction flush, which drops all rename tags.
REQ-006 SHALL have ports rs1_to_reg and rs2_to_reg, input, 6 bits each: source register indices; index >= 32 means no operand.
REQ-007 SHALL have port rd_to_reg, input, 6 bits: destination index of the issuing instruction; index >= 32 means no destination.
REQ-008 SHALL have port issue_valid, input, 1 bit: an instruction issues this cycle.
REQ-009 SHALL have port issue_entry, input, ROB_W bits: ROB entry allocated to the issuing instruction.
REQ-010 SHALL have ports Vj_from_reg and Vk_from_reg, output, 32 bits each: operand values.
REQ-011 SHALL have ports Qj_from_reg and Qk_from_reg, output, ROB_W bits each: producer tags, 0 = value ready.
REQ-012 SHALL have port commit_valid, input, 1 bit: the ROB head retires a register write this cycle.
REQ-013 SHALL have port commit_rd, input, 6 bits: destination index of the committed write.
REQ-014 SHALL have port commit_entry, input, ROB_W bits: ROB entry of the committing instruction.
REQ-015 SHALL have port commit_value, input, 32 bits: result value being committed.

Function
REQ-016 SHALL hold 32 x 32-bit value registers and 32 x ROB_W-bit tag registers; x0 SHALL read value 0 and tag 0 at all times and SHALL never be written or tagged.
REQ-017 SHALL compute read outputs combinationally from the pre-edge state, with zero latency.
REQ-018 SHALL output V=0 and Q=0 for a source index >= 32.
REQ-019 For a source with tag T != 0, SHALL output Q=T and V=stored value.
REQ-020 Commit bypass: if commit_valid, commit_rd equals the source index (not 0), and the tag equals commit_entry, SHALL output V=commit_value and Q=0 in the same cycle.
REQ-021 On an edge with rdy=1 and commit_valid with commit_rd in 1..31, SHALL write commit_value into value[commit_rd].
REQ-022 On that edge, SHALL clear tag[commit_rd] only if it equals commit_entry; otherwise the tag SHALL be left unchanged (a younger producer remains).
REQ-023 On an edge with rdy=1, issue_valid=1, clear=0 and rd_to_reg in 1..31, SHALL set tag[rd_to_reg]=issue_entry.
REQ-024 When issue and commit target the same rd in the same cycle, the issue tag SHALL win and the value write SHALL still occur.
REQ-025 When an issuing instruction reads its own rd (e.g. x1 = x1 + x2), the source read SHALL see the old tag; the rename SHALL take effect the next cycle.
REQ-026 On an edge with rdy=1 and clear=1, SHALL set all tags to 0 and ignore issue; a simultaneous commit value write SHALL still be performed.
REQ-027 With rdy=0, SHALL leave all values and tags unchanged; combinational reads SHALL remain active.

Reset
REQ-028 While rst=0, SHALL force all values and tags to 0 asynchronously, so every read output is 0.
REQ-029 SHALL require no initialization cycles after rst deasserts; an issue on the first edge SHALL take effect.
REQ-030 If rst asserts mid-operation, SHALL abandon pending renames without any partial update.

Verification
REQ-031 Issue rd=5, entry=3 -> next cycle rs1=5 gives Qj=3; commit rd=5, entry=3, value=0xDEAD in the same cycle as the read -> Vj=0xDEAD, Qj=0; the following cycle gives Qj=0 and Vj=0xDEAD from storage.
REQ-032 Issue rd=7, entry=2, then issue rd=7, entry=4, then commit rd=7, entry=2, value=0x11 -> value[7]=0x11 and Qk for rs2=7 stays 4.
REQ-033 Same cycle issue rd=9, entry=6 and commit rd=9, entry=1 (tag 1) -> tag[9]=6 and value[9]=commit_value.
REQ-034 Issue rd=0 or rd=40, and commit rd=0 with value 0x55 -> x0 reads V=0, Q=0; no state changes.
REQ-035 Tags set on x3 and x4, then clear=1 with concurrent issue rd=6 -> all Q=0, tag[6]=0; then rdy=0 with commit -> no change.
REQ-036 Assert rst=0 between edges -> outputs 0 immediately, without waiting for a clock edge.
